// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline definitions: hazard-unit control bundle
// and the default depth of inter-stage buffers.
package pipe_stage_buffer_pkg;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;

  parameter int STAGE_BUFFER_DEPTH = 2;

endpackage

// File: rtl/pipe_stage_buffer.sv
// DEPTH-entry FIFO between two pipeline stages with a
// valid/ready handshake that honours hazard-unit stall/flush.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = STAGE_BUFFER_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  control           stageControl,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    writePointer;
  logic [PW-1:0]    readPointer;
  logic             push;
  logic             pop;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] advance(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign inReady  = !full && !stageControl.stall;
  assign outValid = !empty && !stageControl.stall;
  assign outData  = storage[readPointer];

  assign push = inValid && inReady
             && !stageControl.flush;
  assign pop  = outValid && outReady
             && !stageControl.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      writePointer <= '0;
      readPointer  <= '0;
    end else if (stageControl.flush) begin
      count        <= '0;
      writePointer <= '0;
      readPointer  <= '0;
    end else begin
      if (push) writePointer <= advance(writePointer);
      if (pop)  readPointer  <= advance(readPointer);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Payload storage is deliberately left unreset
  always_ff @(posedge clock) begin
    if (push) storage[writePointer] <= inData;
  end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised inter-stage buffer for the five-stage pipeline: a DEPTH-entry FIFO carrying one packed stage payload (fetchDecodePayload, decodeExecutePayload, executeMemoryPayload or memoryWritebackPayload, flattened to WIDTH bits) between two stages. It generalises the fixed single-register stage boundary to arbitrary depth with a valid/ready handshake. It honours the existing stall/flush control struct, so stages can decouple (e.g. fetch running ahead of a stalled decode) without losing or duplicating instructions.

## Interface
Parameters:
- WIDTH, 32, payload width in bits; set to $bits of the carried payload struct
- DEPTH, 2, number of entries, ≥1; DEPTH≥2 gives one transfer per cycle
- Derived CW = $clog2(DEPTH+1), occupancy counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stageControl  in  control  {stall, flush} from the hazard unit
- inData  in  WIDTH  payload from upstream stage
- inValid  in  1  upstream offers inData
- inReady  out  1  buffer accepts this cycle
- outData  out  WIDTH  head-entry payload
- outValid  out  1  head entry offered downstream
- outReady  in  1  downstream consumes this cycle
- count  out  CW  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage: DEPTH×WIDTH register array, write pointer, read pointer, counter; pointers wrap DEPTH-1 → 0 (DEPTH need not be a power of 2).
- inReady = !full && !stageControl.stall. No combinational path from outReady to inReady.
- outValid = !empty && !stageControl.stall; outData = array[readPointer] (don't-care when empty).
- push = inValid && inReady; pop = outValid && outReady.
- push only: write array[writePointer], writePointer+1, count+1.
- pop only: readPointer+1, count−1.
- push and pop same cycle (possible only when not full): both pointers advance, count unchanged.
- stall: no push, no pop; contents, pointers, count held.
- flush (priority over stall, push, pop): next edge sets count=0, readPointer=writePointer=0; inData in the flush cycle is discarded. Array contents are not cleared.
- inValid while !inReady: ignored; upstream holds its payload.
- Payload valid bit inside inData is passed through untouched; the buffer never inspects it.

## Timing
- Reset (asynchronous assert, released synchronously by the top level): count=0, pointers=0, empty=1, full=0, outValid=0, inReady=1 (if not stalled). Array not reset.
- Latency: an entry pushed at edge N is presented on outData/outValid after edge N (earliest pop at cycle N+1); no same-cycle bypass.
- Throughput: DEPTH≥2 sustains one push and one pop per cycle; DEPTH=1 alternates (full blocks push, so one transfer per two cycles when both sides are ready).
- Full with outReady=1: pop occurs, push refused this cycle; inReady rises the following cycle.
- Flush and stall asserted together: flush wins; after the edge the buffer is empty.
- Reset mid-transfer: all entries are lost, the handshake outputs take their reset values immediately (asynchronously), and no pop is reported.
- count, empty, full are registered-derived; outputs depend combinationally only on state and stageControl.stall.

## Structure
- Uses the existing control struct from pack; no new typedefs.
- Add to pack: parameter int STAGE_BUFFER_DEPTH = 2, the default depth used by the top level.
- Single module, no sub-module; pointer-increment-with-wrap is a local function.

## Test plan
- Fill/drain, DEPTH=4, WIDTH=32: push 0xA0..0xA3 with outReady=0 → full=1, count=4, inReady=0. Then outReady=1 → outData 0xA0,0xA1,0xA2,0xA3 on successive cycles, then empty=1.
- Streaming, DEPTH=2: inValid=outReady=1 for 10 cycles with an incrementing payload → 10 pops with no gaps after the first cycle; count stays at 1.
- Wrap, DEPTH=3: 7 push/pop pairs with values 1..7 → output order is 1..7 and pointers wrap twice.
- Stall: count=2, assert stall for 3 cycles with inValid=outReady=1 → outValid=0, inReady=0, count stays 2, and the head is unchanged after release.
- Flush: count=3, assert flush+stall with inValid=1, data=0xFF → next cycle count=0, empty=1, and 0xFF never appears.
- Reset mid-operation: assert reset asynchronously between edges with count=2 → outValid=0 and count=0 immediately; after release inReady=1.
